// File: rtl/cache_set_ctrl.sv
// Request-side controller for a 4-way set: lookup, LRU victim choice, refill and write-through.
// Optional hit/miss statistics counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_set_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              cpu_resp_hit,
  output logic [ADDR_W-1:0] set_addr,
  output logic              set_try_read,
  output logic              set_try_write,
  output logic [3:0]        set_way_sel,
  output logic [DATA_W-1:0] set_write_data,
  output logic [3:0]        set_reset_age,
  output logic [3:0]        set_increment_age,
  input  logic [DATA_W-1:0] set_data,
  input  logic [7:0]        set_ages,
  input  logic              set_hit_miss,
  input  logic [3:0]        set_hit_miss_set,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_FILL     = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  state_t            state_r, next_state_s;
  logic              ready_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              hit_r;
  logic [3:0]        hit_way_r;
  logic [DATA_W-1:0] set_data_r;
  logic [3:0]        victim_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              accept_s;
  logic [3:0]        fill_way_s;

  // Oldest way wins; strict compare keeps the lowest index on ties.
  function automatic logic [3:0] pick_victim(input logic [7:0] ages);
    logic [1:0] best;
    logic [3:0] sel;
    best = ages[1:0];
    sel  = 4'b0001;
    for (int k = 1; k < 4; k++) begin
      if (ages[2*k +: 2] > best) begin
        best = ages[2*k +: 2];
        sel  = 4'b0001 << k;
      end else begin
        best = best;
        sel  = sel;
      end
    end
    return sel;
  endfunction

  assign accept_s   = (state_r == ST_IDLE) && ready_r && cpu_req_valid;
  assign fill_way_s = we_r ? hit_way_r : victim_r;

  // State register; ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == ST_IDLE);
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:     if (accept_s) next_state_s = ST_LOOKUP; else next_state_s = ST_IDLE;
      ST_LOOKUP:   if (!we_r && set_hit_miss) next_state_s = ST_RESP; else next_state_s = ST_MEM_REQ;
      ST_MEM_REQ:  if (mem_req_ready) next_state_s = ST_MEM_WAIT; else next_state_s = ST_MEM_REQ;
      ST_MEM_WAIT: begin
        if (mem_resp_valid) begin
          if (!we_r || hit_r) next_state_s = ST_FILL; else next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_MEM_WAIT;
        end
      end
      ST_FILL:     next_state_s = ST_RESP;
      ST_RESP:     next_state_s = ST_IDLE;
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // Request, lookup result and refill data capture.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      hit_r      <= 1'b0;
      hit_way_r  <= 4'b0000;
      set_data_r <= {DATA_W{1'b0}};
      victim_r   <= 4'b0000;
      mem_data_r <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        we_r    <= cpu_req_we;
        addr_r  <= cpu_req_addr;
        wdata_r <= cpu_req_wdata;
      end
      if (state_r == ST_LOOKUP) begin
        hit_r      <= set_hit_miss;
        hit_way_r  <= set_hit_miss ? set_hit_miss_set : 4'b0000;
        set_data_r <= set_data;
        victim_r   <= pick_victim(set_ages);
      end
      if ((state_r == ST_MEM_WAIT) && mem_resp_valid && !we_r) begin
        mem_data_r <= mem_resp_data;
      end
    end
  end

  assign cpu_req_ready = ready_r;
  assign set_addr      = addr_r;

  // Moore output decode from state and captured registers.
  always_comb begin
    cpu_resp_valid    = 1'b0;
    cpu_resp_rdata    = {DATA_W{1'b0}};
    cpu_resp_hit      = 1'b0;
    set_try_read      = 1'b0;
    set_try_write     = 1'b0;
    set_way_sel       = 4'b0000;
    set_write_data    = {DATA_W{1'b0}};
    set_reset_age     = 4'b0000;
    set_increment_age = 4'b0000;
    mem_req_valid     = 1'b0;
    mem_req_we        = 1'b0;
    mem_req_addr      = {ADDR_W{1'b0}};
    mem_req_wdata     = {DATA_W{1'b0}};
    case (state_r)
      ST_LOOKUP: set_try_read = 1'b1;
      ST_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_r;
        mem_req_addr  = addr_r;
        mem_req_wdata = we_r ? wdata_r : {DATA_W{1'b0}};
      end
      ST_FILL: begin
        set_try_write     = 1'b1;
        set_way_sel       = fill_way_s;
        set_write_data    = we_r ? wdata_r : mem_data_r;
        set_reset_age     = fill_way_s;
        set_increment_age = ~fill_way_s;
      end
      ST_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_hit   = hit_r;
        if (we_r) begin
          cpu_resp_rdata = {DATA_W{1'b0}};
        end else if (hit_r) begin
          cpu_resp_rdata    = set_data_r;
          set_reset_age     = hit_way_r;
          set_increment_age = ~hit_way_r;
        end else begin
          cpu_resp_rdata = mem_data_r;
        end
      end
      default: cpu_resp_valid = 1'b0;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // Saturating hit/miss counters, bumped once per response.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_hits   <= {STAT_W{1'b0}};
      stat_misses <= {STAT_W{1'b0}};
    end else if (state_r == ST_RESP) begin
      if (hit_r && (stat_hits != {STAT_W{1'b1}})) begin
        stat_hits <= stat_hits + STAT_W'(1);
      end
      if (!hit_r && (stat_misses != {STAT_W{1'b1}})) begin
        stat_misses <= stat_misses + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl: vector table of whole transactions plus reset corner cases.
module tb_cache_set_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int STAT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_resp_valid, cpu_resp_hit;
  logic [31:0] cpu_req_addr, set_addr, mem_req_addr;
  logic [7:0]  cpu_req_wdata, cpu_resp_rdata, set_write_data, set_data, set_ages;
  logic [7:0]  mem_req_wdata, mem_resp_data;
  logic        set_try_read, set_try_write, set_hit_miss;
  logic [3:0]  set_way_sel, set_reset_age, set_increment_age, set_hit_miss_set;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
`ifdef CACHE_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_hits, stat_misses;
`endif

  cache_set_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
    .set_addr(set_addr), .set_try_read(set_try_read), .set_try_write(set_try_write),
    .set_way_sel(set_way_sel), .set_write_data(set_write_data), .set_reset_age(set_reset_age),
    .set_increment_age(set_increment_age), .set_data(set_data), .set_ages(set_ages),
    .set_hit_miss(set_hit_miss), .set_hit_miss_set(set_hit_miss_set),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef CACHE_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  typedef struct {
    logic we; logic [31:0] addr; logic [7:0] wdata;
    logic hm; logic [3:0] hset; logic [7:0] ages; logic [7:0] sdata;
    logic [7:0] mdata; int rdly; logic early;
    int e_resp_cyc; logic e_hit; logic [7:0] e_rdata;
    int e_mem_cnt; logic e_mem_we; logic [7:0] e_mem_wdata;
    int e_fill; logic [3:0] e_way; logic [7:0] e_swdata;
    int e_age_cyc; logic [3:0] e_rst_age; logic [3:0] e_inc_age;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [7:0] wdata,
      input logic hm, input logic [3:0] hset, input logic [7:0] ages, input logic [7:0] sdata,
      input logic [7:0] mdata, input int rdly, input logic early,
      input int rc, input logic eh, input logic [7:0] er, input int mc, input logic mwe,
      input logic [7:0] mwd, input int fc, input logic [3:0] way, input logic [7:0] swd,
      input int ac, input logic [3:0] ra, input logic [3:0] ia);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.hm = hm; v.hset = hset; v.ages = ages;
    v.sdata = sdata; v.mdata = mdata; v.rdly = rdly; v.early = early;
    v.e_resp_cyc = rc; v.e_hit = eh; v.e_rdata = er; v.e_mem_cnt = mc; v.e_mem_we = mwe;
    v.e_mem_wdata = mwd; v.e_fill = fc; v.e_way = way; v.e_swdata = swd;
    v.e_age_cyc = ac; v.e_rst_age = ra; v.e_inc_age = ia;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, cpu_req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, resp_cyc, mem_cnt, fill_cnt, age_cyc, lookup_cnt;
    int bad_addr, bad_mem, ready_busy, both_bits, mem_phase, wait_cnt;
    logic [3:0] way, ra, ia;
    logic [7:0] swd, rdata, mem_wd;
    logic hit, mem_we;
    cyc = 0; resp_cyc = -1; mem_cnt = 0; fill_cnt = 0; age_cyc = 0; lookup_cnt = 0;
    bad_addr = 0; bad_mem = 0; ready_busy = 0; both_bits = 0; mem_phase = 0; wait_cnt = 0;
    way = 4'h0; ra = 4'h0; ia = 4'h0; swd = 8'h00; rdata = 8'h00; mem_wd = 8'h00;
    hit = 1'b0; mem_we = 1'b0;
    wait_ready($sformatf("v%0d_ready", idx));
    set_hit_miss = v.hm; set_hit_miss_set = v.hset; set_ages = v.ages; set_data = v.sdata;
    cpu_req_valid = 1'b1; cpu_req_we = v.we; cpu_req_addr = v.addr; cpu_req_wdata = v.wdata;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0; cpu_req_we = ~v.we; cpu_req_addr = ~v.addr; cpu_req_wdata = ~v.wdata;
    while (resp_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (set_addr !== v.addr) bad_addr++;
      if (cpu_req_ready) ready_busy++;
      if (set_try_read) lookup_cnt++;
      if (set_try_write) begin fill_cnt++; way = set_way_sel; swd = set_write_data; end
      if (set_reset_age != 4'h0 || set_increment_age != 4'h0) begin
        age_cyc++; ra = set_reset_age; ia = set_increment_age;
      end
      if ((set_reset_age & set_increment_age) != 4'h0) both_bits++;
      if (mem_req_valid) begin
        mem_cnt++; mem_we = mem_req_we; mem_wd = mem_req_wdata;
        if (mem_req_addr !== v.addr) bad_mem++;
      end
      if (cpu_resp_valid) begin resp_cyc = cyc; hit = cpu_resp_hit; rdata = cpu_resp_rdata; end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 8'h00;
      case (mem_phase)
        0: if (mem_req_valid) begin
          if (wait_cnt == v.rdly) begin
            mem_req_ready = 1'b1; mem_phase = 1;
            if (v.early) begin mem_resp_valid = 1'b1; mem_resp_data = 8'hFF; end
          end else begin
            wait_cnt++;
          end
        end
        1: begin mem_resp_valid = 1'b1; mem_resp_data = v.mdata; mem_phase = 2; end
        default: mem_phase = mem_phase;
      endcase
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check($sformatf("v%0d_resp_cyc", idx), resp_cyc, v.e_resp_cyc);
    check($sformatf("v%0d_hit", idx), {31'd0, hit}, {31'd0, v.e_hit});
    check($sformatf("v%0d_rdata", idx), {24'd0, rdata}, {24'd0, v.e_rdata});
    check($sformatf("v%0d_lookup_cnt", idx), lookup_cnt, 1);
    check($sformatf("v%0d_mem_cnt", idx), mem_cnt, v.e_mem_cnt);
    if (v.e_mem_cnt > 0) begin
      check($sformatf("v%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, v.e_mem_we});
      check($sformatf("v%0d_mem_wdata", idx), {24'd0, mem_wd}, {24'd0, v.e_mem_wdata});
      check($sformatf("v%0d_mem_addr_bad", idx), bad_mem, 0);
    end
    check($sformatf("v%0d_fill_cnt", idx), fill_cnt, v.e_fill);
    if (v.e_fill > 0) begin
      check($sformatf("v%0d_way_sel", idx), {28'd0, way}, {28'd0, v.e_way});
      check($sformatf("v%0d_set_wdata", idx), {24'd0, swd}, {24'd0, v.e_swdata});
    end
    check($sformatf("v%0d_age_cycles", idx), age_cyc, v.e_age_cyc);
    check($sformatf("v%0d_reset_age", idx), {28'd0, ra}, {28'd0, v.e_rst_age});
    check($sformatf("v%0d_incr_age", idx), {28'd0, ia}, {28'd0, v.e_inc_age});
    check($sformatf("v%0d_age_overlap", idx), both_bits, 0);
    check($sformatf("v%0d_set_addr_stable", idx), bad_addr, 0);
    check($sformatf("v%0d_ready_busy", idx), ready_busy, 0);
  endtask

  task automatic start_read_miss(input logic [31:0] addr);
    wait_ready("rst_seq_ready");
    set_hit_miss = 1'b0; set_hit_miss_set = 4'h0; set_ages = 8'h00;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = addr; cpu_req_wdata = 8'h00;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    for (int n = 0; n < 10 && !mem_req_valid; n++) @(negedge clk);
    check("rst_seq_mem_valid", {31'd0, mem_req_valid}, 32'd1);
  endtask

  task automatic watch_quiet(input string name);
    int bad;
    bad = 0;
    rst_b = 1'b1; mem_resp_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (cpu_resp_valid || set_try_write || mem_req_valid) bad++;
    end
    check({name, "_quiet"}, bad, 0);
    check({name, "_ready_back"}, {31'd0, cpu_req_ready}, 32'd1);
  endtask

  initial begin
    rst_b = 1'b0; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = 32'h0;
    cpu_req_wdata = 8'h00; set_data = 8'h00; set_ages = 8'h00; set_hit_miss = 1'b0;
    set_hit_miss_set = 4'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 8'h00;

    // rd hit w1; rd miss victim w2; wr hit w0; wr miss; slow mem tie->w0; early resp ignored; rd hit w3
    vecs[0] = mk(1'b0, 32'h1000_0040, 8'h00, 1'b1, 4'b0010, 8'b00_01_10_11, 8'h5A, 8'h00, 0, 1'b0,
                 2, 1'b1, 8'h5A, 0, 1'b0, 8'h00, 0, 4'h0, 8'h00, 1, 4'b0010, 4'b1101);
    vecs[1] = mk(1'b0, 32'h2000_0080, 8'h00, 1'b0, 4'b0001, 8'b00_11_01_10, 8'h11, 8'hA5, 0, 1'b0,
                 5, 1'b0, 8'hA5, 1, 1'b0, 8'h00, 1, 4'b0100, 8'hA5, 1, 4'b0100, 4'b1011);
    vecs[2] = mk(1'b1, 32'h3000_00C0, 8'h3C, 1'b1, 4'b0001, 8'b00_00_00_00, 8'h77, 8'h00, 0, 1'b0,
                 5, 1'b1, 8'h00, 1, 1'b1, 8'h3C, 1, 4'b0001, 8'h3C, 1, 4'b0001, 4'b1110);
    vecs[3] = mk(1'b1, 32'h4000_0100, 8'h99, 1'b0, 4'b0000, 8'b11_10_01_00, 8'h22, 8'h00, 0, 1'b0,
                 4, 1'b0, 8'h00, 1, 1'b1, 8'h99, 0, 4'h0, 8'h00, 0, 4'h0, 4'h0);
    vecs[4] = mk(1'b0, 32'h5000_0140, 8'h00, 1'b0, 4'b0000, 8'b01_01_01_01, 8'h33, 8'hC3, 5, 1'b0,
                 10, 1'b0, 8'hC3, 6, 1'b0, 8'h00, 1, 4'b0001, 8'hC3, 1, 4'b0001, 4'b1110);
    vecs[5] = mk(1'b0, 32'h6000_0180, 8'h00, 1'b0, 4'b0000, 8'b11_00_00_10, 8'h44, 8'h42, 0, 1'b1,
                 5, 1'b0, 8'h42, 1, 1'b0, 8'h00, 1, 4'b1000, 8'h42, 1, 4'b1000, 4'b0111);
    vecs[6] = mk(1'b0, 32'h7000_01C0, 8'h00, 1'b1, 4'b1000, 8'b00_00_00_00, 8'hE1, 8'h00, 0, 1'b0,
                 2, 1'b1, 8'hE1, 0, 1'b0, 8'h00, 0, 4'h0, 8'h00, 1, 4'b1000, 4'b0111);

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_set_addr", set_addr, 32'd0);
    check("rst_try_read", {31'd0, set_try_read}, 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

`ifdef CACHE_CTRL_STATS_EN
    @(negedge clk);
    check("stat_hits", 32'(stat_hits), 32'd3);
    check("stat_misses", 32'(stat_misses), 32'd4);
`endif

    // Reset while the memory request is pending: valid must drop without a clock edge.
    start_read_miss(32'h8000_0200);
    #2 rst_b = 1'b0;
    #1 check("rst_memreq_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    @(negedge clk);
    watch_quiet("rst_memreq");

    // Reset while waiting for refill data: the late response must be lost.
    start_read_miss(32'h9000_0240);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst_wait_no_valid", {31'd0, mem_req_valid}, 32'd0);
    #2 rst_b = 1'b0;
    #1 check("rst_wait_resp", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_wait_ready", {31'd0, cpu_req_ready}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 8'h11;
    @(negedge clk);
    watch_quiet("rst_memwait");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
